// File: rtl/seq_div_32.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// WIDTH steps per division, with a one-edge shortcut for a zero divisor.
module seq_div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [WIDTH-1:0] shq_q, shq_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             noBorrow;
  logic [WIDTH:0]   partNext;
  logic [WIDTH-1:0] shqNext;

  // Trial subtraction as an add of the inverted divisor with carry-in 1;
  // a carry out of the top bit means the divisor fit.
  always_comb begin
    shifted  = {part_q[WIDTH-1:0], shq_q[WIDTH-1]};
    trial    = {1'b0, shifted} + {1'b0, ~{1'b0, divisor_q}} + (WIDTH+2)'(1);
    noBorrow = trial[WIDTH+1];
    partNext = noBorrow ? trial[WIDTH:0] : shifted;
    shqNext  = {shq_q[WIDTH-2:0], noBorrow};
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    part_d    = part_q;
    shq_d     = shq_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          divisor_d = divisor_in;
          dbz_d     = 1'b0;
          if (divisor_in != '0) begin
            state_d = RUN;
            count_d = '0;
            part_d  = '0;
            shq_d   = dividend_in;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend_in;
            dbz_d   = 1'b1;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        part_d  = partNext;
        shq_d   = shqNext;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = shqNext;
          rem_d   = partNext[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      part_q    <= '0;
      shq_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      part_q    <= part_d;
      shq_q     <= shq_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient_out  = quot_q;
  assign remainder_out = rem_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_seq_div_32.sv
// Self-checking bench for seq_div_32: directed corner cases plus random
// operands compared against plain integer division.
module tb_seq_div_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend_in = '0;
  logic [31:0] divisor_in = '0;
  logic [31:0] quotient_out;
  logic [31:0] remainder_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  logic [31:0] dirA [4] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
  logic [31:0] dirB [4] = '{32'd7,   32'd1,         32'hFFFF_FFFF, 32'd10};

  seq_div_32 #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend_in(dividend_in),
    .divisor_in(divisor_in),
    .quotient_out(quotient_out),
    .remainder_out(remainder_out),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: ordinary arithmetic, with the all-ones / dividend convention
  // for a zero divisor.
  function automatic logic [31:0] refQuot(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] refRem(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? a : a % b;
  endfunction

  function automatic int refLatency(input logic [31:0] b);
    return (b == 32'd0) ? 1 : 33;
  endfunction

  // Issues one division and waits (bounded) for done; cycle 1 is the
  // sample just after the accepting edge. Operand inputs are scrambled
  // right after capture.
  task automatic runDiv(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic z, output int cyc,
                        output logic sawBusy, output int dones);
    @(negedge clk);
    dividend_in = a;
    divisor_in  = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    dividend_in = $urandom;
    divisor_in  = $urandom;
    cyc     = 1;
    sawBusy = busy;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      sawBusy = sawBusy | busy;
    end
    q = quotient_out;
    r = remainder_out;
    z = div_by_zero;
    dones = done ? 1 : 0;
    @(posedge clk);
    #1;
    if (done) dones++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (quotient_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_quot got=%h exp=%h", quotient_out, 32'd0); end
    checks++; if (remainder_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_rem got=%h exp=%h", remainder_out, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] q, r;
    logic z, sb;
    int cyc, dn;
    for (int i = 0; i < 4; i++) begin
      runDiv(dirA[i], dirB[i], q, r, z, cyc, sb, dn);
      checks++; if (q !== refQuot(dirA[i], dirB[i])) begin errors++; $display("[TB] FAIL dir_quot[%0d] got=%h exp=%h", i, q, refQuot(dirA[i], dirB[i])); end
      checks++; if (r !== refRem(dirA[i], dirB[i])) begin errors++; $display("[TB] FAIL dir_rem[%0d] got=%h exp=%h", i, r, refRem(dirA[i], dirB[i])); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL dir_dbz[%0d] got=%b exp=0", i, z); end
      checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL dir_latency[%0d] got=%0d exp=33", i, cyc); end
      checks++; if (dn != 1) begin errors++; $display("[TB] FAIL dir_donepulse[%0d] got=%0d exp=1", i, dn); end
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] q, r;
    logic z, sb;
    int cyc, dn;
    runDiv(32'd5, 32'd0, q, r, z, cyc, sb, dn);
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL dbz_quot got=%h exp=ffffffff", q); end
    checks++; if (r !== 32'd5) begin errors++; $display("[TB] FAIL dbz_rem got=%h exp=%h", r, 32'd5); end
    checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag got=%b exp=1", z); end
    checks++; if (cyc != 1) begin errors++; $display("[TB] FAIL dbz_latency got=%0d exp=1", cyc); end
    checks++; if (sb !== 1'b0) begin errors++; $display("[TB] FAIL dbz_busy got=%b exp=0", sb); end
    checks++; if (dn != 1) begin errors++; $display("[TB] FAIL dbz_donepulse got=%0d exp=1", dn); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dbz_hold got=%b exp=1", div_by_zero); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic z, sb;
    int cyc, dn;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 5) b = 32'd0;
      runDiv(a, b, q, r, z, cyc, sb, dn);
      checks++; if (q !== refQuot(a, b)) begin errors++; $display("[TB] FAIL rand_quot %h/%h got=%h exp=%h", a, b, q, refQuot(a, b)); end
      checks++; if (r !== refRem(a, b)) begin errors++; $display("[TB] FAIL rand_rem %h/%h got=%h exp=%h", a, b, r, refRem(a, b)); end
      checks++; if (z !== (b == 32'd0)) begin errors++; $display("[TB] FAIL rand_dbz %h/%h got=%b exp=%b", a, b, z, (b == 32'd0)); end
      checks++; if (cyc != refLatency(b)) begin errors++; $display("[TB] FAIL rand_latency %h/%h got=%0d exp=%0d", a, b, cyc, refLatency(b)); end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, dones, firstDone;
    logic [31:0] q, r;
    q = '0; r = '0; dones = 0; firstDone = 0;
    @(negedge clk);
    dividend_in = 32'd100;
    divisor_in  = 32'd7;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 45) begin
      if (cyc == 9) begin
        start = 1'b1; dividend_in = 32'd9; divisor_in = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        dones++;
        if (firstDone == 0) begin firstDone = cyc; q = quotient_out; r = remainder_out; end
      end
    end
    start = 1'b0;
    checks++; if (q !== refQuot(32'd100, 32'd7)) begin errors++; $display("[TB] FAIL busy_start_quot got=%0d exp=%0d", q, refQuot(32'd100, 32'd7)); end
    checks++; if (r !== refRem(32'd100, 32'd7)) begin errors++; $display("[TB] FAIL busy_start_rem got=%0d exp=%0d", r, refRem(32'd100, 32'd7)); end
    checks++; if (firstDone != 33) begin errors++; $display("[TB] FAIL busy_start_latency got=%0d exp=33", firstDone); end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL busy_start_dones got=%0d exp=1", dones); end
  endtask

  task automatic test_back_to_back();
    int cyc, dones, lastDone;
    dones = 0; lastDone = 0;
    @(negedge clk);
    dividend_in = 32'd50;
    divisor_in  = 32'd5;
    start       = 1'b1;
    for (cyc = 1; cyc <= 110; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        checks++; if (quotient_out !== 32'd10) begin errors++; $display("[TB] FAIL b2b_quot got=%0d exp=10", quotient_out); end
        checks++; if (remainder_out !== 32'd0) begin errors++; $display("[TB] FAIL b2b_rem got=%0d exp=0", remainder_out); end
        if (lastDone > 0) begin
          checks++;
          if (cyc - lastDone != 33 && cyc - lastDone != 34) begin
            errors++; $display("[TB] FAIL b2b_interval got=%0d exp=33..34", cyc - lastDone);
          end
        end
        lastDone = cyc;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++; if (dones != 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", dones); end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    logic [31:0] q, r;
    logic z, sb;
    int cyc, dn, stray;
    @(negedge clk);
    dividend_in = 32'd1000;
    divisor_in  = 32'd3;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (quotient_out !== 32'd0) begin errors++; $display("[TB] FAIL abort_quot got=%h exp=0", quotient_out); end
    checks++; if (remainder_out !== 32'd0) begin errors++; $display("[TB] FAIL abort_rem got=%h exp=0", remainder_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL abort_dbz got=%b exp=0", div_by_zero); end
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) stray++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL abort_stray_done got=%0d exp=0", stray); end
    runDiv(32'd1000, 32'd3, q, r, z, cyc, sb, dn);
    checks++; if (q !== 32'd333) begin errors++; $display("[TB] FAIL abort_retry_quot got=%0d exp=333", q); end
    checks++; if (r !== 32'd1) begin errors++; $display("[TB] FAIL abort_retry_rem got=%0d exp=1", r); end
    checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL abort_retry_latency got=%0d exp=33", cyc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
